// File: rtl/kamus_lsu.sv
// Load/store unit: aligns and byte-lanes store data, drives a req/gnt/rvalid
// data-memory port, extends load data and stalls the pipeline while busy.
module kamus_lsu #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              we_i,
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [XLEN-1:0]   wdata_i,
   output logic              resp_valid_o,
   output logic [XLEN-1:0]   rdata_o,
   output logic              misaligned_o,
   output logic              stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [XLEN-1:0]   mem_rdata_i
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} state_e;

   state_e            state_q, state_d;
   logic              we_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   rdata_q;
   logic [3:0]        be_q;

   logic              accept;
   logic              misaligned;
   logic [3:0]        be_d;
   logic [XLEN-1:0]   wrep_d;
   logic [XLEN-1:0]   ext_d;
   logic [7:0]        byte_lane;
   logic [15:0]       half_lane;

   assign accept = req_valid_i && (state_q == IDLE);

   // Request-side decode: alignment check, byte enables, lane replication.
   always_comb begin
      misaligned = 1'b0;
      be_d       = 4'b1111;
      wrep_d     = wdata_i;
      unique case (size_i)
         2'b00: begin
            be_d   = 4'b0001 << addr_i[1:0];
            wrep_d = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            misaligned = addr_i[0];
            be_d       = addr_i[1] ? 4'b1100 : 4'b0011;
            wrep_d     = {2{wdata_i[15:0]}};
         end
         2'b10:   misaligned = |addr_i[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   // Response-side lane select and sign/zero extension from the latched access.
   always_comb begin
      unique case (addr_q[1:0])
         2'b00:   byte_lane = mem_rdata_i[7:0];
         2'b01:   byte_lane = mem_rdata_i[15:8];
         2'b10:   byte_lane = mem_rdata_i[23:16];
         default: byte_lane = mem_rdata_i[31:24];
      endcase
      half_lane = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      unique case (size_q)
         2'b00:   ext_d = {{(XLEN-8){byte_lane[7] & ~uns_q}}, byte_lane};
         2'b01:   ext_d = {{(XLEN-16){half_lane[15] & ~uns_q}}, half_lane};
         default: ext_d = mem_rdata_i;
      endcase
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = misaligned ? ERR : REQ;
         REQ:     if (mem_gnt_i) state_d = we_q ? RESP : WAIT;
         WAIT:    if (mem_rvalid_i) state_d = RESP;
         RESP:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments throughout; reset is synchronous, so
      // it is just the highest-priority branch of the clocked process.
      if (rst_i) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         be_q    <= 4'b0000;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= we_i;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            addr_q  <= addr_i;
            wdata_q <= wrep_d;
            be_q    <= be_d;
            rdata_q <= '0;
         end
         if (state_q == WAIT && mem_rvalid_i) rdata_q <= ext_d;
      end
   end

   assign req_ready_o  = (state_q == IDLE);
   assign stall_o      = (state_q == REQ) || (state_q == WAIT) || accept;
   assign resp_valid_o = (state_q == RESP) || (state_q == ERR);
   assign misaligned_o = (state_q == ERR);
   assign rdata_o      = rdata_q;
   assign mem_req_o    = (state_q == REQ);
   assign mem_we_o     = (state_q == REQ) && we_q;
   assign mem_be_o     = (state_q == REQ) ? be_q : 4'b0000;
   assign mem_addr_o   = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata_o  = wdata_q;

endmodule

// File: doc/kamus_lsu.md
Name: kamus_lsu

Overview:
Load/store unit that executes data-memory accesses requested by the decode/control stage. It consumes the store-enable and access-size controls, aligns and byte-lanes write data, and drives a request/grant/rvalid memory port. It extracts and sign- or zero-extends load data, and stalls the pipeline while a memory transaction is outstanding. It sits between the execute stage (which provides the ALU address) and the L1 data memory.

Parameters:
XLEN, 32, data path width (fixed at 32; byte-lane logic assumes 4 lanes)
ADDR_W, 32, byte address width

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  memory operation present (load or store)
req_ready_o  out  1  LSU can accept a request this cycle
we_i  in  1  1 = store (driven by control unit l1d_wr_en), 0 = load
size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
unsigned_i  in  1  load zero-extend (LBU/LHU); ignored for stores and words
addr_i  in  ADDR_W  byte address from ALU
wdata_i  in  XLEN  store data (rs2)
resp_valid_o  out  1  one-cycle completion pulse
rdata_o  out  XLEN  extended load data, valid with resp_valid_o on a load
misaligned_o  out  1  completion is an alignment error; valid with resp_valid_o
stall_o  out  1  hold the pipeline
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write
mem_addr_o  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}
mem_be_o  out  4  byte enables
mem_wdata_o  out  XLEN  lane-replicated write data
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  read data valid, at least 1 cycle after gnt
mem_rdata_i  in  XLEN  read word

Behaviour:
- States: IDLE, REQ, WAIT, RESP, ERR. Reset state is IDLE.
- Reset values: mem_req_o=0, resp_valid_o=0, misaligned_o=0, rdata_o=0, mem_be_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Reset mid-operation: the transaction is abandoned and the block is in IDLE on the next cycle. A later mem_rvalid_i in IDLE is ignored, and no resp_valid_o is issued.
- req_ready_o = (state==IDLE). An accept occurs when req_valid_i && req_ready_o in cycle T; we, size, unsigned, addr and wdata are latched.
- Misalignment check on accept: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Misaligned -> ERR at T+1: resp_valid_o=1, misaligned_o=1, rdata_o=0, no memory request. Next state IDLE.
  - Aligned -> REQ.
- REQ: mem_req_o=1 from T+1. Address, we, be and wdata are held stable from latched registers until the grant cycle G.
  - On mem_gnt_i: store -> RESP; load -> WAIT.
  - mem_rvalid_i while in REQ is ignored.
- WAIT: mem_req_o=0. On mem_rvalid_i in cycle R, the extended data is registered -> RESP.
- RESP: resp_valid_o=1 for exactly one cycle; rdata_o is valid for loads (0 for stores). Next state IDLE.
  - Store completion is at G+1; load completion is at R+1.
- Byte enables:
  - byte: 1 << addr[1:0]
  - half: 0011 if addr[1]=0, 1100 if addr[1]=1
  - word: 1111
- mem_wdata_o: byte replicated to all 4 lanes; half replicated to both halves; word passed through.
- Load extract: select the lane by addr[1:0] (byte) or addr[1] (half), then sign-extend, or zero-extend if unsigned_i. Words pass through.
- stall_o = (state==REQ) || (state==WAIT) || (state==IDLE && req_valid_i). stall_o is low in RESP and ERR so the pipeline advances with the result.
- No back-to-back accept: the next request is accepted in the IDLE cycle following RESP/ERR.

Test Plan:
- SW, addr 0x10000008, wdata 0xDEADBEEF, gnt held off 2 cycles -> mem_req_o high from T+1 until G; mem_addr_o 0x10000008, be 1111, wdata 0xDEADBEEF all stable; resp_valid_o at G+1 for one cycle.
- LB / LBU, addr 0x00000103, mem_rdata_i 0x80FF0000, rvalid 1 cycle after gnt -> mem_addr_o 0x00000100, be 1000; rdata_o 0xFFFFFF80 (LB) / 0x00000080 (LBU).
- SH, addr 0x00000002, wdata 0x1234ABCD -> be 1100, mem_wdata_o 0xABCDABCD, mem_we_o 1.
- LW, addr 0x00000006 -> no mem_req_o; resp_valid_o=1 and misaligned_o=1 at T+1; IDLE at T+2.
- LH / LHU, addr 0x00000002, mem_rdata_i 0x92345678 -> rdata_o 0xFFFF9234 / 0x00009234.
- rst_i pulsed while in WAIT, then mem_rvalid_i -> IDLE and mem_req_o=0 the cycle after reset; no resp_valid_o; req_ready_o=1.
